// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Latches decoded D-stage fields into E, detects load-use hazards (stall F/D
// for one cycle and insert an E bubble), applies taken-branch flushes, forms
// the forwarded E operands and counts stall/flush events.
//
// Handshake: there is no valid/ready pair here. valid_d/valid_e mark real
// instructions; stall_fd asks the upstream stages to hold for exactly one
// cycle, flush_d asks them to turn IF/ID into a bubble. A flush always wins
// over a stall so the PC redirect is never blocked.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_d,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [4:0]       raddr1_d,
  input  logic [4:0]       raddr2_d,
  input  logic [4:0]       waddr_d,
  input  logic [XLEN-1:0]  rdata1_d,
  input  logic [XLEN-1:0]  rdata2_d,
  input  logic [XLEN-1:0]  imm_d,
  input  logic             reg_wr_d,
  input  logic             mem_wr_d,
  input  logic [1:0]       wb_sel_d,
  input  logic [3:0]       alu_op_d,
  input  logic [2:0]       br_type_d,
  input  logic             br_taken_e,
  input  logic [1:0]       forwardAE,
  input  logic [1:0]       forwardBE,
  input  logic [XLEN-1:0]  alu_result_m,
  input  logic [XLEN-1:0]  wdata_w,
  output logic             valid_e,
  output logic [XLEN-1:0]  pc_e,
  output logic [4:0]       raddr1_e,
  output logic [4:0]       raddr2_e,
  output logic [4:0]       waddr_e,
  output logic [XLEN-1:0]  imm_e,
  output logic             reg_wr_e,
  output logic             mem_wr_e,
  output logic [1:0]       wb_sel_e,
  output logic [3:0]       alu_op_e,
  output logic [2:0]       br_type_e,
  output logic [XLEN-1:0]  opa_e,
  output logic [XLEN-1:0]  opb_e,
  output logic             stall_fd,
  output logic             flush_d,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             valid_q,    valid_d_n;
  logic [XLEN-1:0]  pc_q,       pc_d_n;
  logic [4:0]       raddr1_q,   raddr1_d_n;
  logic [4:0]       raddr2_q,   raddr2_d_n;
  logic [4:0]       waddr_q,    waddr_d_n;
  logic [XLEN-1:0]  rdata1_q,   rdata1_d_n;
  logic [XLEN-1:0]  rdata2_q,   rdata2_d_n;
  logic [XLEN-1:0]  imm_q,      imm_d_n;
  logic             reg_wr_q,   reg_wr_d_n;
  logic             mem_wr_q,   mem_wr_d_n;
  logic [1:0]       wb_sel_q,   wb_sel_d_n;
  logic [3:0]       alu_op_q,   alu_op_d_n;
  logic [2:0]       br_type_q,  br_type_d_n;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic bubble;

  // Load-use detection: a load in E whose destination (never x0) is read by
  // the real instruction in D cannot be covered by forwarding.
  always_comb begin
    lu = valid_q & reg_wr_q & wb_sel_q[1] & (waddr_q != 5'd0) & valid_d &
         ((raddr1_d == waddr_q) | (raddr2_d == waddr_q));
    stall_fd = lu & ~br_taken_e;
    flush_d  = br_taken_e;
    bubble   = br_taken_e | lu;
  end

  // Next E contents: a bubble on flush or load-use, else the D fields.
  always_comb begin
    valid_d_n   = 1'b0;
    pc_d_n      = '0;
    raddr1_d_n  = 5'd0;
    raddr2_d_n  = 5'd0;
    waddr_d_n   = 5'd0;
    rdata1_d_n  = '0;
    rdata2_d_n  = '0;
    imm_d_n     = '0;
    reg_wr_d_n  = 1'b0;
    mem_wr_d_n  = 1'b0;
    wb_sel_d_n  = 2'b00;
    alu_op_d_n  = 4'd0;
    br_type_d_n = 3'b000;
    if (!bubble) begin
      valid_d_n   = valid_d;
      pc_d_n      = pc_d;
      raddr1_d_n  = raddr1_d;
      raddr2_d_n  = raddr2_d;
      waddr_d_n   = waddr_d;
      rdata1_d_n  = rdata1_d;
      rdata2_d_n  = rdata2_d;
      imm_d_n     = imm_d;
      reg_wr_d_n  = reg_wr_d;
      mem_wr_d_n  = mem_wr_d;
      wb_sel_d_n  = wb_sel_d;
      alu_op_d_n  = alu_op_d;
      br_type_d_n = br_type_d;
    end
  end

  // Saturating event counters; a flush cycle never counts as a stall
  // because stall_fd is already masked by br_taken_e.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_fd && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    if (br_taken_e && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Pipeline register and counters; reset leaves a bubble in E.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      raddr1_q    <= 5'd0;
      raddr2_q    <= 5'd0;
      waddr_q     <= 5'd0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      imm_q       <= '0;
      reg_wr_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      wb_sel_q    <= 2'b00;
      alu_op_q    <= 4'd0;
      br_type_q   <= 3'b000;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d_n;
      pc_q        <= pc_d_n;
      raddr1_q    <= raddr1_d_n;
      raddr2_q    <= raddr2_d_n;
      waddr_q     <= waddr_d_n;
      rdata1_q    <= rdata1_d_n;
      rdata2_q    <= rdata2_d_n;
      imm_q       <= imm_d_n;
      reg_wr_q    <= reg_wr_d_n;
      mem_wr_q    <= mem_wr_d_n;
      wb_sel_q    <= wb_sel_d_n;
      alu_op_q    <= alu_op_d_n;
      br_type_q   <= br_type_d_n;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Zero-latency operand forwarding: 00 from M, 10 from W, 01/11 stored value.
  always_comb begin
    case (forwardAE)
      2'b00:   opa_e = alu_result_m;
      2'b10:   opa_e = wdata_w;
      default: opa_e = rdata1_q;
    endcase
    case (forwardBE)
      2'b00:   opb_e = alu_result_m;
      2'b10:   opb_e = wdata_w;
      default: opb_e = rdata2_q;
    endcase
  end

  assign valid_e   = valid_q;
  assign pc_e      = pc_q;
  assign raddr1_e  = raddr1_q;
  assign raddr2_e  = raddr2_q;
  assign waddr_e   = waddr_q;
  assign imm_e     = imm_q;
  assign reg_wr_e  = reg_wr_q;
  assign mem_wr_e  = mem_wr_q;
  assign wb_sel_e  = wb_sel_q;
  assign alu_op_e  = alu_op_q;
  assign br_type_e = br_type_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
